axi4_aw_fifo: RTL and testbench
===============================

Name: axi4_aw_fifo

Overview:
- Parametrised AXI4 write-address channel buffer; successor to the fixed 2-entry AW buffer slice.
- Sits between a slave-side AW port and a master-side AW port inside the RAB datapath. Provides DEPTH-entry in-order storage and configurable address width.
- Exposes fill level and an almost-full flag for upstream throttling and debug.
- Ready is fully registered: no combinational path from m_axi4_awready to s_axi4_awready.

Parameters:
- AXI_ADDR_WIDTH, 32: AW address width, 32..64.
- AXI_ID_WIDTH, 4: awid width, >=1.
- AXI_USER_WIDTH, 4: awuser width, >=1.
- DEPTH, 4: number of entries; power of 2, >=2.
- AFULL_THRESH, DEPTH-1: fill level at or above which afull asserts; 1..DEPTH.

Ports:
- axi4_aclk  in  1  clock.
- axi4_arst  in  1  synchronous active-high reset.
- s_axi4_aw{id,addr,len,size,burst,lock,prot,cache,region,qos,user}  in  ID/ADDR/8/3/2/1/3/4/4/4/USER  slave-side AW payload.
- s_axi4_awvalid  in  1  slave-side valid.
- s_axi4_awready  out  1  slave-side ready.
- m_axi4_aw{id,addr,len,size,burst,lock,prot,cache,region,qos,user}  out  same widths  master-side AW payload.
- m_axi4_awvalid  out  1  master-side valid.
- m_axi4_awready  in  1  master-side ready.
- fill_level  out  $clog2(DEPTH)+1  current number of stored entries.
- afull  out  1  fill_level >= AFULL_THRESH.

Behaviour:
- Storage: DEPTH-entry register array; payload packed as {user, id, qos, region, addr, len, size, burst, lock, prot, cache}, width ADDR+ID+USER+29. Write/read pointers have width $clog2(DEPTH)+1 (extra wrap bit).
- Full: pointer indices equal and wrap bits differ. Empty: pointers equal.
- Push = s_axi4_awvalid & s_axi4_awready.
- Pop = m_axi4_awvalid & m_axi4_awready.
- s_axi4_awready = !full, driven from a register updated each cycle from next-state fill.
- m_axi4_awvalid = !empty, registered. Master payload is read from the array at the read pointer and is stable while valid & !ready.
- Latency: an entry pushed in cycle N is presented with m_axi4_awvalid=1 in cycle N+1; no same-cycle bypass.
- Simultaneous push and pop: allowed when neither full nor empty; fill_level is unchanged and both pointers advance.
- When full, push is impossible (ready=0). A pop in that cycle raises s_axi4_awready in the next cycle.
- When empty, pop is impossible (valid=0). A push raises valid next cycle.
- Pointers wrap modulo 2*DEPTH; the index is the low $clog2(DEPTH) bits.
- fill_level = wr_ptr - rd_ptr, modulo 2*DEPTH.
- afull is registered, consistent with fill_level in the same cycle.
- Payload is accepted whenever valid & ready, irrespective of content; no AXI legality checks.
- Reset, including mid-operation: pointers=0, fill_level=0, afull=0, m_axi4_awvalid=0, s_axi4_awready=0 during reset and 1 in the first cycle after reset deasserts. Stored payloads are discarded. Payload array is not reset; m_axi4_aw* payload is don't-care while valid=0.
- Order is strictly FIFO; no reordering by ID.

Optional Feature:
- Macro AXI4_AW_FIFO_STATS_EN.
- Defined: adds outputs stat_aw_count (32b) and stat_stall_cycles (32b), plus input stat_clear (1b).
  - stat_aw_count increments on every pop.
  - stat_stall_cycles increments on each cycle with m_axi4_awvalid & !m_axi4_awready.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both clear to 0 on reset or on stat_clear=1; clear takes priority over increment in the same cycle.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then single push (addr=0x1000_0040, id=3, len=7), m_awready=1 -> m_awvalid rises exactly 1 cycle later with identical payload; fill_level goes 0→1→0.
- DEPTH=4, m_awready=0, push 5 back-to-back -> 4 accepted; s_awready=0 from the cycle after the 4th push; fill_level=4; afull=1 from fill_level=3. Then release ready -> entries drain in order 0..3 and the 5th is accepted the cycle after the first pop.
- Continuous valid on both sides with random m_awready, 1000 beats, AXI_ADDR_WIDTH=64, addr upper bits set -> output sequence equals input sequence; wrap exercised; no beat lost or duplicated.
- Assert axi4_arst for 1 cycle while fill_level=3 -> next cycle m_awvalid=0, fill_level=0, s_awready=1; previously stored entries never appear on the output.
- Payload held while m_awvalid=1 and m_awready=0 for 10 cycles -> all m_axi4_aw* fields stable; no s_awready→m_awready combinational dependency in a lint/structural check.
- With AXI4_AW_FIFO_STATS_EN: 6 pops and 4 stall cycles -> stat_aw_count=6, stat_stall_cycles=4. stat_clear pulsed concurrently with a pop -> both counters read 0 next cycle.

Source files
------------

// File: rtl/axi4_aw_fifo.sv
// DEPTH-entry in-order AXI4 AW channel buffer with registered ready/valid/afull.
// Define AXI4_AW_FIFO_STATS_EN to add pop and stall counters with a clear input.
module axi4_aw_fifo #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int DEPTH          = 4,
  parameter int AFULL_THRESH   = DEPTH-1
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arst,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi4_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi4_awaddr,
  input  logic [7:0]                s_axi4_awlen,
  input  logic [2:0]                s_axi4_awsize,
  input  logic [1:0]                s_axi4_awburst,
  input  logic                      s_axi4_awlock,
  input  logic [2:0]                s_axi4_awprot,
  input  logic [3:0]                s_axi4_awcache,
  input  logic [3:0]                s_axi4_awregion,
  input  logic [3:0]                s_axi4_awqos,
  input  logic [AXI_USER_WIDTH-1:0] s_axi4_awuser,
  input  logic                      s_axi4_awvalid,
  output logic                      s_axi4_awready,
  output logic [AXI_ID_WIDTH-1:0]   m_axi4_awid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi4_awaddr,
  output logic [7:0]                m_axi4_awlen,
  output logic [2:0]                m_axi4_awsize,
  output logic [1:0]                m_axi4_awburst,
  output logic                      m_axi4_awlock,
  output logic [2:0]                m_axi4_awprot,
  output logic [3:0]                m_axi4_awcache,
  output logic [3:0]                m_axi4_awregion,
  output logic [3:0]                m_axi4_awqos,
  output logic [AXI_USER_WIDTH-1:0] m_axi4_awuser,
  output logic                      m_axi4_awvalid,
  input  logic                      m_axi4_awready,
  output logic [$clog2(DEPTH):0]    fill_level,
`ifdef AXI4_AW_FIFO_STATS_EN
  output logic                      afull,
  input  logic                      stat_clear,
  output logic [31:0]               stat_aw_count,
  output logic [31:0]               stat_stall_cycles
`else
  output logic                      afull
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = AXI_ADDR_WIDTH + AXI_ID_WIDTH + AXI_USER_WIDTH + 29;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] wr_data, rd_data;
  logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill_d;
  logic          s_ready_q, m_valid_q, afull_q;
  logic          push, pop, full_d, empty_d;

  // Ready register comes out of reset high; gating keeps the port low while reset is held.
  assign s_axi4_awready = s_ready_q & ~axi4_arst;
  assign m_axi4_awvalid = m_valid_q;
  assign afull          = afull_q;
  assign fill_level     = wr_ptr_q - rd_ptr_q;

  assign push = s_axi4_awvalid & s_axi4_awready;
  assign pop  = m_valid_q & m_axi4_awready;

  assign wr_ptr_d = wr_ptr_q + (PW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
  assign fill_d   = wr_ptr_d - rd_ptr_d;
  assign full_d   = (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]) && (wr_ptr_d[PW] != rd_ptr_d[PW]);
  assign empty_d  = (wr_ptr_d == rd_ptr_d);

  assign wr_data = {s_axi4_awuser, s_axi4_awid, s_axi4_awqos, s_axi4_awregion, s_axi4_awaddr,
                    s_axi4_awlen, s_axi4_awsize, s_axi4_awburst, s_axi4_awlock, s_axi4_awprot,
                    s_axi4_awcache};
  assign rd_data = mem_q[rd_ptr_q[PW-1:0]];
  assign {m_axi4_awuser, m_axi4_awid, m_axi4_awqos, m_axi4_awregion, m_axi4_awaddr,
          m_axi4_awlen, m_axi4_awsize, m_axi4_awburst, m_axi4_awlock, m_axi4_awprot,
          m_axi4_awcache} = rd_data;

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      s_ready_q <= ~full_d;
      m_valid_q <= ~empty_d;
      afull_q   <= (fill_d >= (PW+1)'(AFULL_THRESH));
    end
  end

  // Payload storage is not reset; a slot is only read while it holds a live entry.
  always_ff @(posedge axi4_aclk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= wr_data;
  end

`ifdef AXI4_AW_FIFO_STATS_EN
  logic [31:0] stat_aw_count_q, stat_stall_cycles_q;

  assign stat_aw_count     = stat_aw_count_q;
  assign stat_stall_cycles = stat_stall_cycles_q;

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst || stat_clear) begin
      stat_aw_count_q     <= '0;
      stat_stall_cycles_q <= '0;
    end else begin
      if (pop && (stat_aw_count_q != '1))
        stat_aw_count_q <= stat_aw_count_q + 32'd1;
      if (m_valid_q && !m_axi4_awready && (stat_stall_cycles_q != '1))
        stat_stall_cycles_q <= stat_stall_cycles_q + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_axi4_aw_fifo.sv
// Randomized bench for axi4_aw_fifo against a queue-based FIFO reference model.
module tb_axi4_aw_fifo;
  localparam int AW = 64;
  localparam int DEPTH = 4;
  localparam int THR = DEPTH-1;
  typedef logic [100:0] pl_t;

  logic clk = 1'b0, arst = 1'b1;
  logic [3:0] s_id, s_region, s_qos, s_user, s_cache, m_id, m_region, m_qos, m_user, m_cache;
  logic [AW-1:0] s_addr, m_addr;
  logic [7:0] s_len, m_len;
  logic [2:0] s_size, s_prot, m_size, m_prot;
  logic [1:0] s_burst, m_burst;
  logic s_lock, m_lock, s_valid, s_ready, m_valid, m_ready, afull;
  logic [2:0] fill;
  pl_t m_pl, cur;
`ifdef AXI4_AW_FIFO_STATS_EN
  logic stat_clear;
  logic [31:0] stat_cnt, stat_stall;
`endif

  int nvec = 0, nerr = 0;
  pl_t q[$];

  always #5 clk = ~clk;

  axi4_aw_fifo #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(4), .DEPTH(DEPTH),
                 .AFULL_THRESH(THR)) dut (
    .axi4_aclk(clk), .axi4_arst(arst),
    .s_axi4_awid(s_id), .s_axi4_awaddr(s_addr), .s_axi4_awlen(s_len), .s_axi4_awsize(s_size),
    .s_axi4_awburst(s_burst), .s_axi4_awlock(s_lock), .s_axi4_awprot(s_prot),
    .s_axi4_awcache(s_cache), .s_axi4_awregion(s_region), .s_axi4_awqos(s_qos),
    .s_axi4_awuser(s_user), .s_axi4_awvalid(s_valid), .s_axi4_awready(s_ready),
    .m_axi4_awid(m_id), .m_axi4_awaddr(m_addr), .m_axi4_awlen(m_len), .m_axi4_awsize(m_size),
    .m_axi4_awburst(m_burst), .m_axi4_awlock(m_lock), .m_axi4_awprot(m_prot),
    .m_axi4_awcache(m_cache), .m_axi4_awregion(m_region), .m_axi4_awqos(m_qos),
    .m_axi4_awuser(m_user), .m_axi4_awvalid(m_valid), .m_axi4_awready(m_ready),
    .fill_level(fill),
`ifdef AXI4_AW_FIFO_STATS_EN
    .afull(afull), .stat_clear(stat_clear), .stat_aw_count(stat_cnt),
    .stat_stall_cycles(stat_stall)
`else
    .afull(afull)
`endif
  );

  assign m_pl = {m_user, m_id, m_qos, m_region, m_addr, m_len, m_size, m_burst, m_lock,
                 m_prot, m_cache};

  task automatic drive(input pl_t p);
    cur = p;
    {s_user, s_id, s_qos, s_region, s_addr, s_len, s_size, s_burst, s_lock, s_prot, s_cache} = p;
  endtask

  function automatic pl_t rnd_pl();
    pl_t p;
    p = pl_t'({$urandom(), $urandom(), $urandom(), $urandom()});
    p[84:81] = 4'hF;
    return p;
  endfunction

  // Reference model: handshakes follow from occupancy alone (ready = not full, valid = not empty).
  task automatic tick();
    bit do_push, do_pop;
    @(negedge clk);
    do_push = s_valid && (q.size() < DEPTH);
    do_pop  = m_ready && (q.size() > 0);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(cur);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    arst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; drive('0);
`ifdef AXI4_AW_FIFO_STATS_EN
    stat_clear = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (s_ready !== 1'b0) begin nerr++; $display("FAIL rst_sready got %b exp 0", s_ready); end
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL rst_mvalid got %b exp 0", m_valid); end
    nvec++; if (fill !== 3'd0) begin nerr++; $display("FAIL rst_fill got %0d exp 0", fill); end
    nvec++; if (afull !== 1'b0) begin nerr++; $display("FAIL rst_afull got %b exp 0", afull); end
    arst = 1'b0; #1;
    q.delete();
    nvec++; if (s_ready !== 1'b1) begin nerr++; $display("FAIL post_rst_sready got %b exp 1", s_ready); end
  endtask

  task automatic test_single_push();
    pl_t p = '0;
    p[84:21] = 64'h1000_0040; p[96:93] = 4'd3; p[20:13] = 8'd7;
    drive(p); s_valid = 1'b1; m_ready = 1'b1;
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL sp_bypass got %b exp 0", m_valid); end
    tick();
    s_valid = 1'b0;
    nvec++; if (m_valid !== 1'b1) begin nerr++; $display("FAIL sp_valid got %b exp 1", m_valid); end
    nvec++; if (m_pl !== p) begin nerr++; $display("FAIL sp_payload got %h exp %h", m_pl, p); end
    nvec++; if (fill !== 3'd1) begin nerr++; $display("FAIL sp_fill1 got %0d exp 1", fill); end
    tick();
    nvec++; if (fill !== 3'd0) begin nerr++; $display("FAIL sp_fill0 got %0d exp 0", fill); end
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL sp_drained got %b exp 0", m_valid); end
  endtask

  task automatic test_back_to_back();
    pl_t v[5];
    for (int i = 0; i < 5; i++) v[i] = rnd_pl();
    m_ready = 1'b0; s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(v[k]);
      nvec++; if (s_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready%0d got %b exp 1", k, s_ready); end
      nvec++; if (fill !== 3'(k)) begin nerr++; $display("FAIL b2b_fill%0d got %0d exp %0d", k, fill, k); end
      nvec++; if (afull !== (k >= THR)) begin nerr++; $display("FAIL b2b_afull%0d got %b exp %b", k, afull, k >= THR); end
      tick();
    end
    drive(v[4]);
    nvec++; if (s_ready !== 1'b0) begin nerr++; $display("FAIL b2b_full_ready got %b exp 0", s_ready); end
    nvec++; if (fill !== 3'd4) begin nerr++; $display("FAIL b2b_full_fill got %0d exp 4", fill); end
    nvec++; if (afull !== 1'b1) begin nerr++; $display("FAIL b2b_full_afull got %b exp 1", afull); end
    nvec++; if (m_pl !== v[0]) begin nerr++; $display("FAIL b2b_out0 got %h exp %h", m_pl, v[0]); end
    m_ready = 1'b1;
    tick();
    nvec++; if (s_ready !== 1'b1) begin nerr++; $display("FAIL b2b_reopen got %b exp 1", s_ready); end
    nvec++; if (fill !== 3'd3) begin nerr++; $display("FAIL b2b_fill3 got %0d exp 3", fill); end
    nvec++; if (m_pl !== v[1]) begin nerr++; $display("FAIL b2b_out1 got %h exp %h", m_pl, v[1]); end
    tick();
    s_valid = 1'b0;
    nvec++; if (fill !== 3'd3) begin nerr++; $display("FAIL b2b_fill_pp got %0d exp 3", fill); end
    for (int k = 2; k < 5; k++) begin
      nvec++; if (m_pl !== v[k]) begin nerr++; $display("FAIL b2b_out%0d got %h exp %h", k, m_pl, v[k]); end
      tick();
    end
    nvec++; if (m_valid !== 1'b0 || fill !== 3'd0) begin nerr++; $display("FAIL b2b_empty got v=%b f=%0d exp v=0 f=0", m_valid, fill); end
  endtask

  task automatic test_hold();
    pl_t snap;
    m_ready = 1'b0; s_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin drive(rnd_pl()); tick(); end
    s_valid = 1'b0;
    snap = q[0];
    for (int k = 0; k < 10; k++) begin
      nvec++; if (m_valid !== 1'b1 || m_pl !== snap) begin nerr++; $display("FAIL hold%0d got v=%b %h exp v=1 %h", k, m_valid, m_pl, snap); end
      tick();
    end
    m_ready = 1'b1;
    repeat (2) tick();
    nvec++; if (fill !== 3'd0) begin nerr++; $display("FAIL hold_drain got %0d exp 0", fill); end
  endtask

  task automatic test_mid_reset();
    pl_t p;
    m_ready = 1'b0; s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin p = rnd_pl(); p[84:53] = 32'hDEAD_BEEF; drive(p); tick(); end
    s_valid = 1'b0;
    nvec++; if (fill !== 3'd3) begin nerr++; $display("FAIL mr_fill3 got %0d exp 3", fill); end
    arst = 1'b1;
    @(posedge clk); #1;
    nvec++; if (s_ready !== 1'b0) begin nerr++; $display("FAIL mr_in_rst_ready got %b exp 0", s_ready); end
    arst = 1'b0; q.delete(); #1;
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL mr_valid got %b exp 0", m_valid); end
    nvec++; if (fill !== 3'd0) begin nerr++; $display("FAIL mr_fill got %0d exp 0", fill); end
    nvec++; if (s_ready !== 1'b1) begin nerr++; $display("FAIL mr_ready got %b exp 1", s_ready); end
    nvec++; if (afull !== 1'b0) begin nerr++; $display("FAIL mr_afull got %b exp 0", afull); end
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s_valid = (k < 2); drive(rnd_pl());
      nvec++; if (m_valid !== (q.size() > 0)) begin nerr++; $display("FAIL mr_v%0d got %b exp %b", k, m_valid, q.size() > 0); end
      if (q.size() > 0) begin
        nvec++; if (m_pl !== q[0]) begin nerr++; $display("FAIL mr_out%0d got %h exp %h", k, m_pl, q[0]); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    int pops = 0;
    s_valid = 1'b1;
    for (int c = 0; c < 5000 && pops < 1000; c++) begin
      drive(rnd_pl());
      m_ready = 1'($urandom_range(0, 1));
      nvec++; if (fill !== 3'(q.size())) begin nerr++; $display("FAIL rnd_fill c%0d got %0d exp %0d", c, fill, q.size()); end
      nvec++; if (s_ready !== (q.size() < DEPTH)) begin nerr++; $display("FAIL rnd_ready c%0d got %b exp %b", c, s_ready, q.size() < DEPTH); end
      nvec++; if (afull !== (q.size() >= THR)) begin nerr++; $display("FAIL rnd_afull c%0d got %b exp %b", c, afull, q.size() >= THR); end
      nvec++; if (m_valid !== (q.size() > 0)) begin nerr++; $display("FAIL rnd_valid c%0d got %b exp %b", c, m_valid, q.size() > 0); end
      if (q.size() > 0) begin
        nvec++; if (m_pl !== q[0]) begin nerr++; $display("FAIL rnd_out c%0d got %h exp %h", c, m_pl, q[0]); end
        if (m_ready) pops++;
      end
      tick();
    end
    nvec++; if (pops < 1000) begin nerr++; $display("FAIL rnd_budget got %0d pops exp 1000", pops); end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      nvec++; if (m_pl !== q[0]) begin nerr++; $display("FAIL rnd_drain got %h exp %h", m_pl, q[0]); end
      tick();
    end
    nvec++; if (fill !== 3'd0 || m_valid !== 1'b0) begin nerr++; $display("FAIL rnd_empty got f=%0d v=%b exp 0 0", fill, m_valid); end
  endtask

`ifdef AXI4_AW_FIFO_STATS_EN
  task automatic test_stats();
    s_valid = 1'b0; m_ready = 1'b0; stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    s_valid = 1'b1; drive(rnd_pl()); tick();
    s_valid = 1'b0; repeat (4) tick();
    s_valid = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin drive(rnd_pl()); tick(); end
    s_valid = 1'b0; tick();
    nvec++; if (stat_cnt !== 32'd6) begin nerr++; $display("FAIL st_count got %0d exp 6", stat_cnt); end
    nvec++; if (stat_stall !== 32'd4) begin nerr++; $display("FAIL st_stall got %0d exp 4", stat_stall); end
    s_valid = 1'b1; m_ready = 1'b0; drive(rnd_pl()); tick();
    s_valid = 1'b0; m_ready = 1'b1; stat_clear = 1'b1; tick();
    stat_clear = 1'b0;
    nvec++; if (stat_cnt !== 32'd0) begin nerr++; $display("FAIL st_clr_count got %0d exp 0", stat_cnt); end
    nvec++; if (stat_stall !== 32'd0) begin nerr++; $display("FAIL st_clr_stall got %0d exp 0", stat_stall); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_push();
    test_back_to_back();
    test_hold();
    test_mid_reset();
    test_random();
`ifdef AXI4_AW_FIFO_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
